temp_alarm_ctrl: RTL and testbench

Consumes the one-hot temperature classification flags (normal, border_line, warning, emergency) produced by the temperature-state stage.
- Filters the flags for persistence.
- Latches emergencies until an operator acknowledge.
- Drives a level-dependent blinking alarm LED and a level-change strobe.
- Sits between temperature classification and the board LEDs/keys.

---
 rtl/temp_alarm_ctrl.sv | 158 +++++++++++++++
 tb/tb_temp_alarm_ctrl.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/temp_alarm_ctrl.sv
// rtl/temp_alarm_ctrl.sv - persistence-filtered temperature alarm with emergency latch and blinking LED
// Optional emergency entry counter: define TEMP_ALARM_EVENT_COUNT_EN.
module temp_alarm_ctrl #(
  parameter int TICK_DIV      = 5000000,
  parameter int PERSIST_TICKS = 3,
  parameter int BLINK_BORDER  = 8,
  parameter int BLINK_WARN    = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       normal,
  input  logic       border_line,
  input  logic       warning,
  input  logic       emergency,
  input  logic       ack,
  output logic [1:0] alarm_level,
  output logic       alarm_latched,
  output logic       led_blink,
  output logic       level_changed,
  output logic       input_err,
  output logic [7:0] event_count
);

  localparam int DIV_W     = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
  localparam int PER_W     = $clog2(PERSIST_TICKS + 1);
  localparam int BLINK_MAX = (BLINK_BORDER > BLINK_WARN) ? BLINK_BORDER : BLINK_WARN;
  localparam int BLK_W     = (BLINK_MAX > 2) ? $clog2(BLINK_MAX) : 1;

  localparam logic [1:0] LVL_NORMAL = 2'd0;
  localparam logic [1:0] LVL_BORDER = 2'd1;
  localparam logic [1:0] LVL_WARN   = 2'd2;
  localparam logic [1:0] LVL_EMERG  = 2'd3;

  localparam logic [DIV_W-1:0] DIV_LAST    = DIV_W'(TICK_DIV - 1);
  localparam logic [PER_W-1:0] PER_MAX     = PER_W'(PERSIST_TICKS);
  localparam logic [BLK_W-1:0] BORDER_LAST = BLK_W'(BLINK_BORDER - 1);
  localparam logic [BLK_W-1:0] WARN_LAST   = BLK_W'(BLINK_WARN - 1);

  logic [3:0]       flags;
  logic             one_hot;
  logic [1:0]       raw;
  logic [DIV_W-1:0] div_cnt;
  logic             tick;
  logic [1:0]       candidate;
  logic [PER_W-1:0] persist_cnt;
  logic [PER_W-1:0] persist_nxt;
  logic             stable;
  logic             persisted;
  logic [1:0]       level_nxt;
  logic             latched_nxt;
  logic [BLK_W-1:0] blink_cnt;
  logic [BLK_W-1:0] blink_last;

  assign flags   = {emergency, warning, border_line, normal};
  assign one_hot = (flags != 4'd0) && ((flags & (flags - 4'd1)) == 4'd0);

  always_comb begin
    raw = LVL_NORMAL;
    if (emergency)        raw = LVL_EMERG;
    else if (warning)     raw = LVL_WARN;
    else if (border_line) raw = LVL_BORDER;
  end

  assign tick = (div_cnt == DIV_LAST);

  always_ff @(posedge clk) begin
    if (rst || tick) div_cnt <= '0;
    else             div_cnt <= div_cnt + DIV_W'(1);
  end

  // A tick in the same cycle as a candidate change is discarded, since the count restarts.
  assign stable = (raw == candidate);

  always_comb begin
    persist_nxt = persist_cnt;
    if (!stable)
      persist_nxt = '0;
    else if (tick && (persist_cnt != PER_MAX))
      persist_nxt = persist_cnt + PER_W'(1);
  end

  assign persisted = stable && (persist_nxt == PER_MAX);

  always_comb begin
    level_nxt   = alarm_level;
    latched_nxt = alarm_latched;
    if (raw == LVL_EMERG) begin
      level_nxt   = LVL_EMERG;
      latched_nxt = 1'b1;
    end else if (alarm_latched) begin
      // Level stays pinned at emergency until an ack arrives with the input out of emergency.
      if (ack) begin
        latched_nxt = 1'b0;
        if (persisted) level_nxt = candidate;
      end
    end else if (persisted) begin
      level_nxt = candidate;
    end
  end

  always_comb begin
    case (alarm_level)
      LVL_BORDER: blink_last = BORDER_LAST;
      LVL_WARN:   blink_last = WARN_LAST;
      default:    blink_last = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      candidate     <= LVL_NORMAL;
      persist_cnt   <= '0;
      alarm_level   <= LVL_NORMAL;
      alarm_latched <= 1'b0;
      level_changed <= 1'b0;
      input_err     <= 1'b0;
      blink_cnt     <= '0;
      led_blink     <= 1'b0;
    end else begin
      candidate     <= raw;
      persist_cnt   <= persist_nxt;
      alarm_level   <= level_nxt;
      alarm_latched <= latched_nxt;
      level_changed <= (level_nxt != alarm_level);
      input_err     <= !one_hot;
      if (level_nxt != alarm_level) begin
        blink_cnt <= '0;
        led_blink <= (level_nxt != LVL_NORMAL);
      end else if (alarm_level == LVL_NORMAL) begin
        blink_cnt <= '0;
        led_blink <= 1'b0;
      end else if (tick) begin
        if (blink_cnt >= blink_last) begin
          blink_cnt <= '0;
          led_blink <= ~led_blink;
        end else begin
          blink_cnt <= blink_cnt + BLK_W'(1);
        end
      end
    end
  end

`ifdef TEMP_ALARM_EVENT_COUNT_EN
  logic [7:0] event_cnt_q;

  always_ff @(posedge clk) begin
    if (rst)
      event_cnt_q <= 8'd0;
    else if (latched_nxt && !alarm_latched && (event_cnt_q != 8'hFF))
      event_cnt_q <= event_cnt_q + 8'd1;
  end

  assign event_count = event_cnt_q;
`else
  assign event_count = 8'd0;
`endif

endmodule

// File: tb/tb_temp_alarm_ctrl.sv
// tb/tb_temp_alarm_ctrl.sv - directed vector bench for temp_alarm_ctrl (TICK_DIV=4, PERSIST_TICKS=3)
module tb_temp_alarm_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       normal, border_line, warning, emergency, ack;
  logic [1:0] alarm_level;
  logic       alarm_latched, led_blink, level_changed, input_err;
  logic [7:0] event_count;

  int checks = 0;
  int errors = 0;

`ifdef TEMP_ALARM_EVENT_COUNT_EN
  localparam int EVT_MID = 10;
  localparam int EVT_END = 255;
`else
  localparam int EVT_MID = 0;
  localparam int EVT_END = 0;
`endif

  always #5 clk = ~clk;

  temp_alarm_ctrl #(
    .TICK_DIV(4), .PERSIST_TICKS(3), .BLINK_BORDER(8), .BLINK_WARN(4)
  ) dut (
    .clk(clk), .rst(rst),
    .normal(normal), .border_line(border_line), .warning(warning), .emergency(emergency),
    .ack(ack),
    .alarm_level(alarm_level), .alarm_latched(alarm_latched), .led_blink(led_blink),
    .level_changed(level_changed), .input_err(input_err), .event_count(event_count)
  );

  typedef struct {
    logic       rst;
    logic [3:0] flags;
    logic       ack;
    int         cycles;
    logic [1:0] level;
    logic       latched;
    logic       led;
    logic       chg;
    logic       err;
  } vec_t;

  vec_t vq[$];

  task automatic add(input logic r, input logic [3:0] f, input logic a, input int n,
                     input logic [1:0] lv, input logic la, input logic ld,
                     input logic ch, input logic er);
    vec_t v;
    v.rst = r; v.flags = f; v.ack = a; v.cycles = n;
    v.level = lv; v.latched = la; v.led = ld; v.chg = ch; v.err = er;
    vq.push_back(v);
  endtask

  task automatic check(input string name, input int idx, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("FAIL %s vec=%0d actual=%0d expected=%0d", name, idx, actual, expected);
    end
  endtask

  task automatic drive(input logic r, input logic [3:0] f, input logic a);
    rst = r;
    {emergency, warning, border_line, normal} = f;
    ack = a;
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    // flags {emergency, warning, border_line, normal}; comments give edges since reset release
    add(1, 4'b1100, 0,  2, 2'd0, 0, 0, 0, 0);  // reset with conflicting flags
    add(0, 4'b0001, 0,  8, 2'd0, 0, 0, 0, 0);  // T8
    add(0, 4'b0100, 0,  1, 2'd0, 0, 0, 0, 0);  // T9  candidate -> warning
    add(0, 4'b0100, 0, 10, 2'd0, 0, 0, 0, 0);  // T19 two ticks only
    add(0, 4'b0100, 0,  1, 2'd2, 0, 1, 1, 0);  // T20 third tick accepts
    add(0, 4'b0100, 0,  1, 2'd2, 0, 1, 0, 0);  // T21 strobe is one cycle
    add(0, 4'b0100, 0, 14, 2'd2, 0, 1, 0, 0);  // T35
    add(0, 4'b0100, 0,  1, 2'd2, 0, 0, 0, 0);  // T36 4th tick toggles LED
    add(0, 4'b0001, 0, 11, 2'd2, 0, 0, 0, 0);  // T47
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 1, 0);  // T48 back to normal
    add(0, 4'b0100, 0,  8, 2'd0, 0, 0, 0, 0);  // T56 warning for 2 ticks
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 0, 0);  // T57 dropped before acceptance
    add(0, 4'b0001, 0, 11, 2'd0, 0, 0, 0, 0);  // T68
    add(0, 4'b1000, 0,  1, 2'd3, 1, 1, 1, 0);  // T69 emergency fast path
    add(0, 4'b0001, 0,  1, 2'd3, 1, 1, 0, 0);  // T70
    add(0, 4'b0001, 0,  2, 2'd3, 1, 0, 0, 0);  // T72 toggles on tick
    add(0, 4'b0001, 0,  4, 2'd3, 1, 1, 0, 0);  // T76
    add(0, 4'b1000, 1,  1, 2'd3, 1, 1, 0, 0);  // T77 ack during emergency ignored
    add(0, 4'b0001, 0, 11, 2'd3, 1, 0, 0, 0);  // T88 latch holds despite persistence
    add(0, 4'b0001, 1,  1, 2'd0, 0, 0, 1, 0);  // T89 ack with persisted normal
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 0, 0);  // T90
    add(0, 4'b1000, 0,  1, 2'd3, 1, 1, 1, 0);  // T91
    add(0, 4'b0001, 1,  1, 2'd3, 0, 0, 0, 0);  // T92 early ack: unlatch, level held
    add(0, 4'b0001, 0, 11, 2'd3, 0, 0, 0, 0);  // T103
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 1, 0);  // T104 persistence completes
    add(0, 4'b0001, 1,  1, 2'd0, 0, 0, 0, 0);  // T105 ack while unlatched
    add(0, 4'b1100, 0,  1, 2'd3, 1, 1, 1, 1);  // T106 multi-flag, emergency wins
    add(0, 4'b0000, 0,  1, 2'd3, 1, 1, 0, 1);  // T107 no flags
    add(0, 4'b0000, 0,  9, 2'd3, 1, 0, 0, 1);  // T116
    add(0, 4'b0000, 1,  1, 2'd0, 0, 0, 1, 1);  // T117 zero flags treated as normal
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 0, 0);  // T118
    add(0, 4'b0110, 0, 10, 2'd2, 0, 1, 1, 1);  // T128 warning beats border_line
    add(0, 4'b0010, 0,  1, 2'd2, 0, 1, 0, 0);  // T129
    add(0, 4'b0010, 0, 11, 2'd1, 0, 1, 1, 0);  // T140 border accepted
    add(0, 4'b0010, 0, 31, 2'd1, 0, 1, 0, 0);  // T171 seven ticks
    add(0, 4'b0010, 0,  1, 2'd1, 0, 0, 0, 0);  // T172 eighth tick toggles
    add(0, 4'b1000, 0,  1, 2'd3, 1, 1, 1, 0);  // T173
    add(1, 4'b1000, 0,  1, 2'd0, 0, 0, 0, 0);  // reset mid-latch
    add(0, 4'b0001, 0,  1, 2'd0, 0, 0, 0, 0);  // latch did not survive reset

    foreach (vq[i]) begin
      drive(vq[i].rst, vq[i].flags, vq[i].ack);
      step(vq[i].cycles);
      check("alarm_level",   i, int'(alarm_level),   int'(vq[i].level));
      check("alarm_latched", i, int'(alarm_latched), int'(vq[i].latched));
      check("led_blink",     i, int'(led_blink),     int'(vq[i].led));
      check("level_changed", i, int'(level_changed), int'(vq[i].chg));
      check("input_err",     i, int'(input_err),     int'(vq[i].err));
      if (vq[i].rst) check("event_count_reset", i, int'(event_count), 0);
    end

    for (int k = 0; k < 300; k++) begin
      drive(0, 4'b1000, 0);
      step(1);
      drive(0, 4'b0001, 1);
      step(1);
      if (k == 9) check("event_count_mid", k, int'(event_count), EVT_MID);
    end
    drive(0, 4'b0001, 0);
    step(1);
    check("event_count_sat", 300, int'(event_count), EVT_END);
    check("latched_after_loop", 300, int'(alarm_latched), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
